// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: owner codes, one-hot win
// bit positions and default widths.
package mem_bus_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int REG_WIDTH_DEF  = 8;

    localparam int WIN_F = 0;
    localparam int WIN_E = 1;
    localparam int WIN_D = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_F    = 2'b01,
        OWN_E    = 2'b10,
        OWN_D    = 2'b11
    } owner_e;

    typedef enum logic {
        BUS_OPEN   = 1'b0,
        BUS_LOCKED = 1'b1
    } bus_state_e;

    function automatic owner_e win_to_owner(input logic [2:0] win);
        if (win[WIN_D]) return OWN_D;
        if (win[WIN_E]) return OWN_E;
        if (win[WIN_F]) return OWN_F;
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_prio_sel.sv
// Combinational winner select: lock reserves the bus for D, a starved F
// pre-empts everything else, otherwise D > E > F.
module arb_prio_sel
    import mem_bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic       locked,
    input  logic       starve_hit,
    output logic [2:0] win
);

    always_comb begin
        win = 3'b000;
        if (locked) begin
            win[WIN_D] = req[WIN_D];
        end else if (starve_hit && req[WIN_F]) begin
            win[WIN_F] = 1'b1;
        end else if (req[WIN_D]) begin
            win[WIN_D] = 1'b1;
        end else if (req[WIN_E]) begin
            win[WIN_E] = 1'b1;
        end else if (req[WIN_F]) begin
            win[WIN_F] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one registered memory port between fetch (F), execute (E) and
// OAM DMA (D); one transfer per cycle, locked DMA bursts, F anti-starvation.
//
// state      | meaning
// BUS_OPEN   | normal priority arbitration
// BUS_LOCKED | bus reserved for D until it ends or aborts its burst
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int REG_WIDTH    = REG_WIDTH_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [REG_WIDTH-1:0]  e_wdata,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_lock,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [REG_WIDTH-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic [1:0]            owner,
    output logic                  locked
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    bus_state_e bus_q, bus_next;
    owner_e     owner_q, rd_tag_q;
    logic [3:0] starve_q, starve_next;
    logic [2:0] win;
    logic       lock_eff, starve_hit, win_we;

    // An abort (d_req low while locked) opens the bus for this same arbitration.
    assign lock_eff   = (bus_q == BUS_LOCKED) && d_req;
    assign starve_hit = (starve_q == STARVE_MAX);

    arb_prio_sel u_prio_sel (
        .req        ({d_req, e_req, f_req}),
        .locked     (lock_eff),
        .starve_hit (starve_hit),
        .win        (win)
    );

    always_ff @(posedge clk) begin
        if (reset) bus_q <= BUS_OPEN;
        else       bus_q <= bus_next;
    end

    always_comb begin
        bus_next = bus_q;
        case (bus_q)
            BUS_OPEN:   if (win[WIN_D] && d_lock) bus_next = BUS_LOCKED;
            BUS_LOCKED: if (!d_req || (win[WIN_D] && !d_lock)) bus_next = BUS_OPEN;
            default:    bus_next = BUS_OPEN;
        endcase
    end

    always_comb begin
        starve_next = starve_q;
        if (!f_req || win[WIN_F]) begin
            starve_next = 4'd0;
        end else if (!lock_eff && (starve_q < STARVE_MAX)) begin
            starve_next = starve_q + 4'd1;
        end
    end

    assign win_we = (win[WIN_D] && d_we) || (win[WIN_E] && e_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= OWN_NONE;
            rd_tag_q  <= OWN_NONE;
            starve_q  <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            owner_q  <= win_to_owner(win);
            rd_tag_q <= mem_re ? owner_q : OWN_NONE;
            starve_q <= starve_next;
            mem_we   <= (|win) && win_we;
            mem_re   <= (|win) && !win_we;
            if (win[WIN_D]) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (win[WIN_E]) begin
                mem_addr  <= e_addr;
                mem_wdata <= e_wdata;
            end else if (win[WIN_F]) begin
                mem_addr  <= f_addr;
            end
        end
    end

    assign owner    = owner_q;
    assign locked   = (bus_q == BUS_LOCKED);
    assign f_gnt    = (owner_q == OWN_F);
    assign e_gnt    = (owner_q == OWN_E);
    assign d_gnt    = (owner_q == OWN_D);
    assign f_rvalid = (rd_tag_q == OWN_F);
    assign e_rvalid = (rd_tag_q == OWN_E);
    assign d_rvalid = (rd_tag_q == OWN_D);
    assign rdata    = mem_rdata;

endmodule
